fxp_mult_pipe: RTL

//  Pipelined signed fixed-point multiplier with independent operand and result Q-formats.

---
 rtl/fxp_mult_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fxp_mult_pipe.sv
// fxp_mult_pipe: pipelined signed fixed-point multiplier with valid/ready on both sides.
//   The product is rounded to nearest, with exact halves rounded toward +inf.
//   Stage 0 registers the full product. Middle stages only retime it. The last stage
//   registers the rounded (and optionally limited) result.
//   Optional feature macro: FXP_MULT_SAT_EN. When defined, results outside the
//   OutWidth range saturate and raise ovf_o. When undefined, results wrap and ovf_o is 0.
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   s_valid_i, s_ready_o  operand handshake; a_i is Q(AWidth-APoint).APoint, b_i is likewise
//   m_valid_o, m_ready_i  result handshake
//   m_o, ovf_o            product Q(OutWidth-OutPoint).OutPoint, overflow flag
// OutWidth must not exceed AWidth+BWidth+1.
module fxp_mult_pipe #(
  parameter int unsigned AWidth   = 16,
  parameter int unsigned BWidth   = 16,
  parameter int unsigned OutWidth = 16,
  parameter int unsigned APoint   = 10,
  parameter int unsigned BPoint   = 10,
  parameter int unsigned OutPoint = 10,
  parameter int unsigned Stages   = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [AWidth-1:0]   a_i,
  input  logic [BWidth-1:0]   b_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [OutWidth-1:0] m_o,
  output logic                ovf_o
);

  localparam int unsigned PW  = AWidth + BWidth;
  localparam int unsigned Lsb = (APoint + BPoint >= OutPoint) ? APoint + BPoint - OutPoint : 0;

  if (APoint + BPoint < OutPoint) begin : g_bad_point
    $error("fxp_mult_pipe: APoint+BPoint must be >= OutPoint");
  end
  if (Stages < 1) begin : g_bad_stages
    $error("fxp_mult_pipe: Stages must be >= 1");
  end

  // Handshake control
  logic [Stages-1:0] v_q, v_in, en, ld;

  // en[k]: stage k may load this cycle (empty, or its content leaves now).
  // A running scalar is used so the ripple is not a self-dependent vector.
  always_comb begin
    logic e;
    en = '0;
    e  = !v_q[Stages-1] || m_ready_i;
    en[Stages-1] = e;
    for (int k = int'(Stages) - 2; k >= 0; k--) begin
      e     = !v_q[k] || e;
      en[k] = e;
    end
  end

  always_comb begin
    v_in    = '0;
    v_in[0] = s_valid_i;
    for (int k = 1; k < int'(Stages); k++) begin
      v_in[k] = v_q[k-1];
    end
  end

  assign ld        = en & v_in;
  assign s_ready_o = en[0] && !rst_i;
  assign m_valid_o = v_q[Stages-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q <= '0;
    end else begin
      v_q <= (en & v_in) | (~en & v_q);
    end
  end

  // Multiply and retiming
  logic signed [PW-1:0] prod, last_p;
  assign prod = PW'($signed(a_i)) * PW'($signed(b_i));

  if (Stages == 1) begin : g_single
    assign last_p = prod;
  end else begin : g_retime
    logic signed [PW-1:0] p_q [Stages-1];
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int k = 0; k < int'(Stages) - 1; k++) begin
          p_q[k] <= '0;
        end
      end else begin
        if (ld[0]) begin
          p_q[0] <= prod;
        end
        for (int k = 1; k < int'(Stages) - 1; k++) begin
          if (ld[k]) begin
            p_q[k] <= p_q[k-1];
          end
        end
      end
    end
    assign last_p = p_q[Stages-2];
  end

  // Rounding, one extra bit so the half-LSB add cannot overflow
  logic signed [PW:0] r;
  if (Lsb > 0) begin : g_round
    localparam logic signed [PW:0] Half = (PW+1)'(1) << (Lsb - 1);
    logic signed [PW:0] rsum;
    assign rsum = $signed({last_p[PW-1], last_p}) + Half;
    assign r    = rsum >>> Lsb;
  end else begin : g_exact
    assign r = $signed({last_p[PW-1], last_p});
  end

  logic [OutWidth-1:0] m_d, m_q;

`ifdef FXP_MULT_SAT_EN
  logic fits, ovf_d, ovf_q;
  // Fits when all bits from the result sign bit upward agree.
  assign fits = (r[PW:OutWidth-1] == {(PW - OutWidth + 2){r[PW]}});

  always_comb begin
    m_d   = r[OutWidth-1:0];
    ovf_d = 1'b0;
    if (!fits) begin
      ovf_d = 1'b1;
      m_d   = r[PW] ? {1'b1, {(OutWidth-1){1'b0}}} : {1'b0, {(OutWidth-1){1'b1}}};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (ld[Stages-1]) begin
      ovf_q <= ovf_d;
    end
  end
  assign ovf_o = ovf_q;
`else
  logic unused_r_hi;
  assign m_d         = r[OutWidth-1:0];
  assign ovf_o       = 1'b0;
  assign unused_r_hi = ^r[PW:OutWidth];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_q <= '0;
    end else if (ld[Stages-1]) begin
      m_q <= m_d;
    end
  end
  assign m_o = m_q;

endmodule
